pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Next-generation MIPS pipeline controller.
- Decodes the ID-stage instruction and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use and RAW hazards (stall/bubble), generates EX-stage forwarding selects, and produces PC-select/IF-flush for branches and jumps.
- Sits between the IF/ID register and the datapath; replaces the purely combinational decoder.

Parameters:
- REG_ADDR_W, 5, register-address width; link register = all-ones (31 at default).
- FWD_EN, 1, 1 = forwarding enabled; 0 = every RAW hazard resolved by stalling.
- OP_W, 6, opcode/func field width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OP_W  ID-stage opcode.
- func  in  OP_W  ID-stage function field.
- id_rs, id_rt, id_rd  in  REG_ADDR_W  ID-stage register fields.
- operands_equal  in  1  ID-stage comparator result (rs==rt).
- stall  out  1  hold PC and IF/ID; ID/EX receives a bubble.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 register (jr).
- if_flush  out  1  zero the IF/ID register.
- ex_alu_src, ex_operation[2:0], ex_fwd_a[1:0], ex_fwd_b[1:0]  out  EX-stage controls.
- mem_read, mem_write  out  1 each  MEM-stage controls.
- wb_reg_write  out  1; wb_mem_to_reg  out  2; wb_dst  out  REG_ADDR_W  WB-stage controls.

Behaviour:
- Decode (ID, combinational). Fields are {reg_dst, mem_to_reg, reg_write, alu_src, mem_read, mem_write, op}:
  - R-type 000000: reg_dst=01, reg_write. Op from func: 100000 add→010, 100010 sub→110, 100100 and→000, 100101 or→001, 101010 slt→111, other→000.
  - lw 100011: alu_src, mem_to_reg=01, reg_write, mem_read, op=010.
  - sw 101011: alu_src, mem_write, op=010.
  - addi 001001: alu_src, reg_write, op=010.
  - slti 001010: alu_src, reg_write, op=111.
  - jal 000011: reg_dst=10, mem_to_reg=10, reg_write.
  - beq 000100, j 000010, jr 000110, and unknown opcodes: no write/mem controls.
- Destination (registered into ID/EX): reg_dst 00→rt, 01→rd, 10→link register. A destination of 0 never counts as a hazard producer.
- Sources: rs is used by R-type, lw, sw, addi, slti, beq, jr. rt is used by R-type, sw, beq.
- Hazard stall, combinational:
  - Always: the EX-stage instruction has mem_read, and its dst matches a used ID source.
  - FWD_EN=0: additionally any EX or MEM stage with reg_write whose dst matches a used ID source.
  - When stall=1: IF/ID and PC hold; ID/EX loads a bubble (all controls 0); pc_src=00; if_flush=0.
- Control flow, only when stall=0:
  - beq: pc_src=01 and if_flush=1 if operands_equal, else 00/0.
  - j and jal: 10/1.
  - jr: 11/1.
- Pipeline registers advance every cycle. EX/MEM and MEM/WB never stall. A bubble propagates as a NOP.
- Forwarding, computed in EX, only when FWD_EN=1 (otherwise ex_fwd_a/ex_fwd_b are constant 00):
  - ex_fwd_a = 01 if MEM reg_write and mem_dst≠0 and mem_dst==ex_rs.
  - Else 10 if WB reg_write and wb_dst≠0 and wb_dst==ex_rs.
  - Else 00.
  - ex_fwd_b uses the same rules on ex_rt. MEM has priority over WB.
  - The register file writes before it reads in the same cycle, so WB→ID needs no action.
- Reset (synchronous): all three pipeline registers are cleared to a bubble. During the reset cycle and the cycle after, every output is 0 except outputs derived combinationally from the ID inputs. Reset mid-stall discards the bubble and in-flight instructions.
- Latency: a decoded instruction's controls appear on ex_* 1 cycle, mem_* 2 cycles and wb_* 3 cycles after its ID cycle, each delay counted with no stall.

Test Plan:
- R-type add, func 100000, rd=3: ex_operation=010 at ID+1, no stall; at ID+3 wb_reg_write=1 and wb_dst=3.
- lw r2 then add using r2 as rs: stall=1 for exactly 1 cycle; the EX slot holds a bubble; then ex_fwd_a=10 (WB forward); with FWD_EN=0, stall lasts 2 cycles and fwd stays 00.
- addi r5 then sub using r5 as rt: no stall; ex_fwd_b=01. The same dst in both MEM and WB selects 01. A dst of r0 gives 00.
- beq with operands_equal=1: pc_src=01 and if_flush=1. With 0: pc_src=00 and if_flush=0. beq arriving during a load-use stall: pc_src=00 until the stall clears.
- jal: pc_src=10 and if_flush=1; at ID+3 wb_dst=31, wb_mem_to_reg=10, wb_reg_write=1. jr: pc_src=11.
- rst asserted with lw in EX and a dependent instruction in ID: next cycle all pipeline controls are 0 and stall=0.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Pipelined MIPS control unit: decodes in ID and carries the control bundle through the
// ID/EX, EX/MEM and MEM/WB registers. It also produces the hazard stall, the EX forwarding selects and the PC select.
module pipelined_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1,
    parameter int OP_W       = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OP_W-1:0]       opcode,
    input  logic [OP_W-1:0]       func,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  operands_equal,
    output logic                  stall,
    output logic [1:0]            pc_src,
    output logic                  if_flush,
    output logic                  ex_alu_src,
    output logic [2:0]            ex_operation,
    output logic [1:0]            ex_fwd_a,
    output logic [1:0]            ex_fwd_b,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  wb_reg_write,
    output logic [1:0]            wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_dst
);
    localparam logic [OP_W-1:0] OPC_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OPC_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OPC_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OPC_ADDI  = OP_W'(6'b001001);
    localparam logic [OP_W-1:0] OPC_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OPC_JAL   = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OPC_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OPC_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OPC_JR    = OP_W'(6'b000110);
    localparam logic [OP_W-1:0] FN_ADD    = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] FN_SUB    = OP_W'(6'b100010);
    localparam logic [OP_W-1:0] FN_AND    = OP_W'(6'b100100);
    localparam logic [OP_W-1:0] FN_OR     = OP_W'(6'b100101);
    localparam logic [OP_W-1:0] FN_SLT    = OP_W'(6'b101010);
    localparam logic [REG_ADDR_W-1:0] LINK_REG = '1;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            mem_to_reg;
        logic                  alu_src;
        logic                  mem_read;
        logic                  mem_write;
        logic [2:0]            op;
        logic [REG_ADDR_W-1:0] dst;
    } ctrl_t;

    ctrl_t                 id_ctrl;
    ctrl_t                 ex_ctrl_reg, ex_ctrl_next;
    logic [REG_ADDR_W-1:0] ex_rs_reg, ex_rs_next, ex_rt_reg, ex_rt_next;
    logic                  mem_reg_write_reg, mem_read_reg, mem_write_reg;
    logic [1:0]            mem_to_reg_reg;
    logic [REG_ADDR_W-1:0] mem_dst_reg;
    logic                  wb_reg_write_reg;
    logic [1:0]            wb_mem_to_reg_reg;
    logic [REG_ADDR_W-1:0] wb_dst_reg;
    logic [1:0]            reg_dst;
    logic                  use_rs, use_rt, is_beq, is_jump, is_jr;
    logic                  ex_hit, mem_hit, live;

    assign live = !rst;

    always_comb begin
        id_ctrl = '0;
        reg_dst = 2'b00;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        is_beq  = 1'b0;
        is_jump = 1'b0;
        is_jr   = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                reg_dst           = 2'b01;
                id_ctrl.reg_write = 1'b1;
                use_rs            = 1'b1;
                use_rt            = 1'b1;
                case (func)
                    FN_ADD:  id_ctrl.op = 3'b010;
                    FN_SUB:  id_ctrl.op = 3'b110;
                    FN_AND:  id_ctrl.op = 3'b000;
                    FN_OR:   id_ctrl.op = 3'b001;
                    FN_SLT:  id_ctrl.op = 3'b111;
                    default: id_ctrl.op = 3'b000;
                endcase
            end
            OPC_LW: begin
                id_ctrl.alu_src    = 1'b1;
                id_ctrl.mem_to_reg = 2'b01;
                id_ctrl.reg_write  = 1'b1;
                id_ctrl.mem_read   = 1'b1;
                id_ctrl.op         = 3'b010;
                use_rs             = 1'b1;
            end
            OPC_SW: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.mem_write = 1'b1;
                id_ctrl.op        = 3'b010;
                use_rs            = 1'b1;
                use_rt            = 1'b1;
            end
            OPC_ADDI, OPC_SLTI: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.reg_write = 1'b1;
                id_ctrl.op        = (opcode == OPC_SLTI) ? 3'b111 : 3'b010;
                use_rs            = 1'b1;
            end
            OPC_JAL: begin
                reg_dst            = 2'b10;
                id_ctrl.mem_to_reg = 2'b10;
                id_ctrl.reg_write  = 1'b1;
                is_jump            = 1'b1;
            end
            OPC_BEQ: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                is_beq = 1'b1;
            end
            OPC_J:  is_jump = 1'b1;
            OPC_JR: begin
                use_rs = 1'b1;
                is_jr  = 1'b1;
            end
            default: ;
        endcase
        case (reg_dst)
            2'b01:   id_ctrl.dst = id_rd;
            2'b10:   id_ctrl.dst = LINK_REG;
            default: id_ctrl.dst = id_rt;
        endcase
        // Non-writers carry dst 0 so they can never look like a hazard producer
        if (!id_ctrl.reg_write) id_ctrl.dst = '0;
    end

    assign ex_hit  = (ex_ctrl_reg.dst != '0) &&
                     ((use_rs && ex_ctrl_reg.dst == id_rs) || (use_rt && ex_ctrl_reg.dst == id_rt));
    assign mem_hit = (mem_dst_reg != '0) &&
                     ((use_rs && mem_dst_reg == id_rs) || (use_rt && mem_dst_reg == id_rt));
    assign stall   = live && ((ex_ctrl_reg.mem_read && ex_hit) ||
                     (!FWD_EN && ((ex_ctrl_reg.reg_write && ex_hit) || (mem_reg_write_reg && mem_hit))));

    always_comb begin
        pc_src   = 2'b00;
        if_flush = 1'b0;
        if (!stall) begin
            if (is_beq && operands_equal) begin
                pc_src   = 2'b01;
                if_flush = 1'b1;
            end else if (is_jump) begin
                pc_src   = 2'b10;
                if_flush = 1'b1;
            end else if (is_jr) begin
                pc_src   = 2'b11;
                if_flush = 1'b1;
            end
        end
    end

    assign ex_ctrl_next = stall ? '0 : id_ctrl;
    assign ex_rs_next   = stall ? '0 : id_rs;
    assign ex_rt_next   = stall ? '0 : id_rt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_reg       <= '0;
            ex_rs_reg         <= '0;
            ex_rt_reg         <= '0;
            mem_reg_write_reg <= 1'b0;
            mem_to_reg_reg    <= 2'b00;
            mem_read_reg      <= 1'b0;
            mem_write_reg     <= 1'b0;
            mem_dst_reg       <= '0;
            wb_reg_write_reg  <= 1'b0;
            wb_mem_to_reg_reg <= 2'b00;
            wb_dst_reg        <= '0;
        end else begin
            ex_ctrl_reg       <= ex_ctrl_next;
            ex_rs_reg         <= ex_rs_next;
            ex_rt_reg         <= ex_rt_next;
            mem_reg_write_reg <= ex_ctrl_reg.reg_write;
            mem_to_reg_reg    <= ex_ctrl_reg.mem_to_reg;
            mem_read_reg      <= ex_ctrl_reg.mem_read;
            mem_write_reg     <= ex_ctrl_reg.mem_write;
            mem_dst_reg       <= ex_ctrl_reg.dst;
            wb_reg_write_reg  <= mem_reg_write_reg;
            wb_mem_to_reg_reg <= mem_to_reg_reg;
            wb_dst_reg        <= mem_dst_reg;
        end
    end

    // Operand 0 is rs (fwd_a), operand 1 is rt (fwd_b); MEM beats WB
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [REG_ADDR_W-1:0] src;
        logic [1:0]            sel;
        assign src = (gi == 0) ? ex_rs_reg : ex_rt_reg;
        always_comb begin
            sel = 2'b00;
            if (FWD_EN && live) begin
                if (mem_reg_write_reg && mem_dst_reg != '0 && mem_dst_reg == src)
                    sel = 2'b01;
                else if (wb_reg_write_reg && wb_dst_reg != '0 && wb_dst_reg == src)
                    sel = 2'b10;
            end
        end
    end

    assign ex_fwd_a      = g_fwd[0].sel;
    assign ex_fwd_b      = g_fwd[1].sel;
    // Registered outputs read as zero while reset is held
    assign ex_alu_src    = live & ex_ctrl_reg.alu_src;
    assign ex_operation  = live ? ex_ctrl_reg.op : 3'b000;
    assign mem_read      = live & mem_read_reg;
    assign mem_write     = live & mem_write_reg;
    assign wb_reg_write  = live & wb_reg_write_reg;
    assign wb_mem_to_reg = live ? wb_mem_to_reg_reg : 2'b00;
    assign wb_dst        = live ? wb_dst_reg : '0;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: a cycle-by-cycle vector table against the forwarding build,
// plus hand sequences comparing the forwarding and stall-only builds.
module tb_pipelined_control_unit;
    localparam logic [5:0] NOP  = 6'h3f, RT = 6'h00, LW = 6'h23, SW = 6'h2b, ADDI = 6'h09;
    localparam logic [5:0] SLTI = 6'h0a, JAL = 6'h03, BEQ = 6'h04, J = 6'h02, JR = 6'h06;
    localparam logic [5:0] FADD = 6'h20, FSUB = 6'h22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [5:0] opcode = NOP, func = 6'h00;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       operands_equal = 1'b0;

    logic       stall, if_flush, ex_alu_src, mem_read, mem_write, wb_reg_write;
    logic [1:0] pc_src, ex_fwd_a, ex_fwd_b, wb_mem_to_reg;
    logic [2:0] ex_operation;
    logic [4:0] wb_dst;
    logic       nf_stall, nf_if_flush, nf_ex_alu_src, nf_mem_read, nf_mem_write, nf_wb_reg_write;
    logic [1:0] nf_pc_src, nf_ex_fwd_a, nf_ex_fwd_b, nf_wb_mem_to_reg;
    logic [2:0] nf_ex_operation;
    logic [4:0] nf_wb_dst;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .operands_equal(operands_equal), .stall(stall), .pc_src(pc_src),
        .if_flush(if_flush), .ex_alu_src(ex_alu_src), .ex_operation(ex_operation),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .mem_read(mem_read), .mem_write(mem_write),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst)
    );

    pipelined_control_unit #(.FWD_EN(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .operands_equal(operands_equal), .stall(nf_stall), .pc_src(nf_pc_src),
        .if_flush(nf_if_flush), .ex_alu_src(nf_ex_alu_src), .ex_operation(nf_ex_operation),
        .ex_fwd_a(nf_ex_fwd_a), .ex_fwd_b(nf_ex_fwd_b), .mem_read(nf_mem_read),
        .mem_write(nf_mem_write), .wb_reg_write(nf_wb_reg_write),
        .wb_mem_to_reg(nf_wb_mem_to_reg), .wb_dst(nf_wb_dst)
    );

    typedef struct {
        logic       r;
        logic [5:0] op, fn;
        logic [4:0] rs, rt, rd;
        logic       eq;
        logic       st;
        logic [1:0] pc;
        logic       fl;
        logic [2:0] exop;
        logic       alu;
        logic [1:0] fa, fb;
        logic       mr, mw, we;
        logic [1:0] m2r;
        logic [4:0] dst;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t v(input logic r, input logic [5:0] op, fn, input logic [4:0] rs, rt, rd,
                               input logic eq, st, input logic [1:0] pc, input logic fl,
                               input logic [2:0] exop, input logic alu, input logic [1:0] fa, fb,
                               input logic mr, mw, we, input logic [1:0] m2r, input logic [4:0] dst);
        vec_t t;
        t.r = r; t.op = op; t.fn = fn; t.rs = rs; t.rt = rt; t.rd = rd; t.eq = eq;
        t.st = st; t.pc = pc; t.fl = fl; t.exop = exop; t.alu = alu; t.fa = fa; t.fb = fb;
        t.mr = mr; t.mw = mw; t.we = we; t.m2r = m2r; t.dst = dst;
        return t;
    endfunction

    task automatic drive(input logic r, input logic [5:0] op, fn, input logic [4:0] rs, rt, rd,
                         input logic eq);
        @(posedge clk);
        #1;
        rst = r; opcode = op; func = fn; id_rs = rs; id_rt = rt; id_rd = rd; operands_equal = eq;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    initial begin
        logic [21:0] got, expv;
        // r  op    fn    rs rt rd eq | st pc   fl exop    alu fa     fb     mr mw we m2r    dst
        tbl.push_back(v(1, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, RT,   FADD, 1, 2, 3, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 3));
        tbl.push_back(v(0, LW,   0,    0, 2, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, RT,   FADD, 2, 4, 6, 0,  1, 2'b00, 0, 3'b010, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, RT,   FADD, 2, 4, 6, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 1, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b010, 0, 2'b10, 2'b00, 0, 0, 1, 2'b01, 2));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 6));
        tbl.push_back(v(0, ADDI, 0,    0, 5, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, RT,   FSUB, 0, 5, 7, 0,  0, 2'b00, 0, 3'b010, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b110, 0, 2'b00, 2'b01, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 5));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 7));
        tbl.push_back(v(0, ADDI, 0,    0, 5, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, ADDI, 0,    0, 5, 0, 0,  0, 2'b00, 0, 3'b010, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, RT,   FADD, 0, 5, 8, 0,  0, 2'b00, 0, 3'b010, 1, 2'b00, 2'b01, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b010, 0, 2'b00, 2'b01, 0, 0, 1, 2'b00, 5));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 5));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 8));
        tbl.push_back(v(0, ADDI, 0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, RT,   FSUB, 0, 0, 9, 0,  0, 2'b00, 0, 3'b010, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b110, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 9));
        tbl.push_back(v(0, BEQ,  0,    1, 2, 0, 1,  0, 2'b01, 1, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, BEQ,  0,    1, 2, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, JAL,  0,    0, 0, 0, 0,  0, 2'b10, 1, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, JR,   0,    0, 0, 0, 0,  0, 2'b11, 1, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, J,    0,    0, 0, 0, 0,  0, 2'b10, 1, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 1, 2'b10, 31));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, LW,   0,    0, 3, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, BEQ,  0,    3, 0, 0, 1,  1, 2'b00, 0, 3'b010, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, BEQ,  0,    3, 0, 0, 1,  0, 2'b01, 1, 3'b000, 0, 2'b00, 2'b00, 1, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b10, 2'b00, 0, 0, 1, 2'b01, 3));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, SW,   0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, SLTI, 0,    0, 4, 0, 0,  0, 2'b00, 0, 3'b010, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b111, 1, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 4));
        tbl.push_back(v(0, LW,   0,    0, 2, 0, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, RT,   FADD, 2, 0, 3, 0,  1, 2'b00, 0, 3'b010, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(1, RT,   FADD, 2, 0, 3, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, RT,   FADD, 2, 0, 3, 0,  0, 2'b00, 0, 3'b000, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));
        tbl.push_back(v(0, NOP,  0,    0, 0, 0, 0,  0, 2'b00, 0, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].op, tbl[i].fn, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].eq);
            got  = {stall, pc_src, if_flush, ex_operation, ex_alu_src, ex_fwd_a, ex_fwd_b,
                    mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_dst};
            expv = {tbl[i].st, tbl[i].pc, tbl[i].fl, tbl[i].exop, tbl[i].alu, tbl[i].fa, tbl[i].fb,
                    tbl[i].mr, tbl[i].mw, tbl[i].we, tbl[i].m2r, tbl[i].dst};
            $display("[TB] row %0d op=%h rst=%0d got=%b", i, tbl[i].op, tbl[i].r, got);
            chk($sformatf("row%0d", i), 32'(got), 32'(expv));
        end

        // Load-use with and without forwarding, then an unused-source field matching a MEM producer
        drive(1, NOP, 0, 0, 0, 0, 0);
        chk("nf_reset_stall", 32'(nf_stall), 32'd0);
        drive(0, LW, 0, 0, 2, 0, 0);
        chk("nf_lw_stall", 32'(nf_stall), 32'd0);
        drive(0, RT, FADD, 2, 4, 6, 0);
        chk("nf_use_stall1", 32'(nf_stall), 32'd1);
        chk("fw_use_stall1", 32'(stall), 32'd1);
        drive(0, RT, FADD, 2, 4, 6, 0);
        chk("nf_use_stall2", 32'(nf_stall), 32'd1);
        chk("fw_use_clear", 32'(stall), 32'd0);
        drive(0, RT, FADD, 2, 4, 6, 0);
        chk("nf_use_clear", 32'(nf_stall), 32'd0);
        chk("fw_wb_fwd_a", 32'(ex_fwd_a), 32'd2);
        chk("nf_fwd_a_idle", 32'(nf_ex_fwd_a), 32'd0);
        drive(0, ADDI, 0, 0, 5, 0, 0);
        chk("nf_addi_stall", 32'(nf_stall), 32'd0);
        drive(0, J, 0, 5, 0, 0, 0);
        chk("nf_j_stall", 32'(nf_stall), 32'd0);
        chk("nf_j_pc_src", 32'(nf_pc_src), 32'd2);
        drive(0, NOP, 0, 0, 0, 0, 0);
        chk("fw_mem_fwd_a", 32'(ex_fwd_a), 32'd1);
        chk("nf_fwd_a_const", 32'(nf_ex_fwd_a), 32'd0);
        chk("nf_fwd_b_const", 32'(nf_ex_fwd_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
